mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single main-memory port (the burst-capable PSRAM memory controller) between the CPU-side cache refill port (master 0) and a second bus master such as DMA or video fetch (master 1). It sits between the masters' memory-style interfaces and the memory controller's `a/d/we/rd/spo/ready/burst_en/burst_length` port. Arbitration is round-robin. A grant is held for the whole transaction, bursts included. A watchdog completes stalled transactions with an error pulse.

## Interface
- `TIMEOUT`, 4096 — cycles without `mem_ready` during a grant before the watchdog fires; must be ≥ 2.
- `ERR_WORD`, 32'hDEADBEEF — read data returned on a watchdog completion.
- `clk` in 1 — system clock (`clk_main` domain).
- `rst` in 1 — synchronous, active-high reset.
- `m0_burst_en`, `m1_burst_en` in 1 — burst request qualifier.
- `m0_burst_length`, `m1_burst_length` in 8 — burst word count.
- `m0_a`, `m1_a` in 32 — address.
- `m0_d`, `m1_d` in 32 — write data.
- `m0_we`, `m1_we` in 1 — write request, level.
- `m0_rd`, `m1_rd` in 1 — read request, level.
- `m0_spo`, `m1_spo` out 32 — read data.
- `m0_ready`, `m1_ready` out 1 — per-word completion strobe.
- `mem_burst_en` out 1, `mem_burst_length` out 8, `mem_a` out 32, `mem_d` out 32, `mem_we` out 1, `mem_rd` out 1 — to the memory controller.
- `mem_spo` in 32, `mem_ready` in 1 — from the memory controller.
- `grant` out 2 — one-hot current owner; 2'b00 when no master owns the port.
- `timeout_irq` out 1 — one-cycle pulse when the watchdog fires.

## Operation
- **Request semantics.** A master requests when `rd | we` is high. It holds `a`, `d`, `burst_*` and the request stable until its last `ready`, then deasserts the request. During a burst, `ready` pulses once per word.
- **States:** IDLE, GRANT0, GRANT1, RELEASE.
- **IDLE**
  - Only m0 requesting → GRANT0.
  - Only m1 requesting → GRANT1.
  - Both requesting → the master ≠ `last` wins.
  - No request → stay in IDLE.
  - `last` is updated to the winner on entry to a GRANT state.
- **GRANTx**
  - All `mem_*` outputs are combinationally driven from master x.
  - `mx_spo = mem_spo`, `mx_ready = mem_ready`.
  - The other master sees `ready=0` and `spo=0`.
  - When master x's `rd|we` is low → RELEASE.
- **RELEASE**
  - Lasts exactly one cycle with all `mem_*` outputs at 0, so the controller observes idle between owners.
  - Then → IDLE.
- **Mem outputs outside GRANTx:** all `mem_*` are 0 in IDLE and RELEASE.
- **Watchdog**
  - `wd_cnt` (log2(TIMEOUT)+1 bits) clears on entry to a GRANT state and on every `mem_ready`.
  - Otherwise it increments each GRANT cycle.
  - When `wd_cnt == TIMEOUT-1` and `mem_ready` is low, then in that cycle:
    - `mx_ready=1`
    - `mx_spo=ERR_WORD`
    - `timeout_irq=1`
    - `wd_cnt` clears.
  - The state is unchanged; the master then drops its request normally.
- **Simultaneous events**
  - A request deasserted in the same cycle the other master raises one: RELEASE still occurs, and the other master is granted from IDLE.
  - `mem_ready` coinciding with the timeout compare: a real completion; no irq, real `mem_spo` is passed through.
  - A master raising a request while the other owns the port waits; there is no preemption.

## Timing
- **Reset values:** state=IDLE, `last`=1 (m0 wins the first tie), `wd_cnt`=0, `grant`=0, `timeout_irq`=0, all `mem_*`=0, all `mx_ready`=0, all `mx_spo`=0.
- **Reset mid-transaction:** outputs return to reset values on the next edge. The in-flight controller operation is abandoned; the controller shares the reset domain.
- **Grant latency:** a request first seen in cycle N gives `mem_rd`/`mem_we` high in cycle N+1.
- **Ready path:** `mx_ready`/`mx_spo` are combinational from `mem_ready`/`mem_spo` (zero added latency).
- **Turnaround:** last `ready` in cycle R, request dropped in R+1 → RELEASE in R+2 → IDLE in R+3. The earliest next grant is R+4.
- **Registered outputs:** `grant` and the state are registered; `grant` is one-hot exactly while in GRANT0/GRANT1.

## Test plan
- **Single read, m0.** m0 reads 0x8000_0010; controller returns 0x1234_5678 with ready 3 cycles after `mem_rd`. Required:
  - `mem_rd` rises 1 cycle after the request.
  - `m0_spo` = 0x1234_5678 on the `m0_ready` cycle.
  - `grant` = 01, then 00 after RELEASE.
  - `m1_ready` stays 0 throughout.
- **Simultaneous requests.** m0 and m1 request in the same cycle after reset. Required:
  - m0 is granted first.
  - With both re-requesting continuously, grants alternate m1, m0, m1.
  - One RELEASE cycle with `mem_rd=mem_we=0` between every pair.
- **Burst.** m1 issues a burst read with `burst_length`=8. Required:
  - 8 `m1_ready` pulses.
  - `grant` stays 10 for the whole burst.
  - An m0 request raised mid-burst is granted only after m1 drops its request plus RELEASE.
- **Watchdog.** `TIMEOUT`=16; controller never asserts ready on an m0 write. Required:
  - On the 16th grant cycle: `m0_ready`=1, `m0_spo`=0xDEADBEEF, `timeout_irq`=1 for exactly one cycle.
  - Same stall with `mem_ready` arriving exactly on cycle 16: no irq, real data returned.
- **Reset mid-grant.** Assert `rst` during GRANT1. Required:
  - The next edge gives `grant`=00 and all `mem_*`=0.
  - The following tie is won by m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the PSRAM controller port between two masters.
// Ownership is held for the whole transaction; a watchdog completes stalled words with ERR_WORD.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_burst_en,
    input  logic [7:0]  m0_burst_length,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,

    input  logic        m1_burst_en,
    input  logic [7:0]  m1_burst_length,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,

    output logic        mem_burst_en,
    output logic [7:0]  mem_burst_length,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [31:0] mem_spo,
    input  logic        mem_ready,

    output logic [1:0]  grant,
    output logic        timeout_irq
);

    localparam int unsigned   WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [1:0]      grant_q, grant_d;

    logic req0, req1, in_grant, wd_fire;

    assign req0     = m0_rd | m0_we;
    assign req1     = m1_rd | m1_we;
    assign in_grant = (state_q == GRANT0) || (state_q == GRANT1);
    // A real completion on the compare cycle wins over the watchdog.
    assign wd_fire  = in_grant && (wd_cnt_q == WD_LAST) && !mem_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
            grant_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
            grant_q  <= grant_d;
        end
    end

    // NOTE: every variable gets a default at the top of a comb block so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wd_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0:  if (!req0) state_d = RELEASE;
            GRANT1:  if (!req1) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (in_grant && !mem_ready && !wd_fire) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        case (state_d)
            GRANT0:  grant_d = 2'b01;
            GRANT1:  grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_comb begin
        mem_burst_en     = 1'b0;
        mem_burst_length = 8'h00;
        mem_a            = 32'h0;
        mem_d            = 32'h0;
        mem_we           = 1'b0;
        mem_rd           = 1'b0;
        m0_ready         = 1'b0;
        m0_spo           = 32'h0;
        m1_ready         = 1'b0;
        m1_spo           = 32'h0;
        timeout_irq      = wd_fire;
        case (state_q)
            GRANT0: begin
                mem_burst_en     = m0_burst_en;
                mem_burst_length = m0_burst_length;
                mem_a            = m0_a;
                mem_d            = m0_d;
                mem_we           = m0_we;
                mem_rd           = m0_rd;
                m0_ready         = mem_ready | wd_fire;
                m0_spo           = wd_fire ? ERR_WORD : mem_spo;
            end
            GRANT1: begin
                mem_burst_en     = m1_burst_en;
                mem_burst_length = m1_burst_length;
                mem_a            = m1_a;
                mem_d            = m1_d;
                mem_we           = m1_we;
                mem_rd           = m1_rd;
                m1_ready         = mem_ready | wd_fire;
                m1_spo           = wd_fire ? ERR_WORD : mem_spo;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked every cycle
// against an owner/queue level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       m_be = '0;
    logic [1:0][7:0]  m_bl = '0;
    logic [1:0][31:0] m_a  = '0;
    logic [1:0][31:0] m_d  = '0;
    logic [1:0]       m_we = '0;
    logic [1:0]       m_rd = '0;

    logic [31:0] m0_spo, m1_spo;
    logic        m0_ready, m1_ready;
    logic        mem_burst_en;
    logic [7:0]  mem_burst_length;
    logic [31:0] mem_a, mem_d;
    logic        mem_we, mem_rd;
    logic [31:0] mem_spo   = '0;
    logic        mem_ready = 1'b0;
    logic [1:0]  grant;
    logic        timeout_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
        .clk(clk), .rst(rst),
        .m0_burst_en(m_be[0]), .m0_burst_length(m_bl[0]), .m0_a(m_a[0]), .m0_d(m_d[0]),
        .m0_we(m_we[0]), .m0_rd(m_rd[0]), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_burst_en(m_be[1]), .m1_burst_length(m_bl[1]), .m1_a(m_a[1]), .m1_d(m_d[1]),
        .m1_we(m_we[1]), .m1_rd(m_rd[1]), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .mem_burst_en(mem_burst_en), .mem_burst_length(mem_burst_length),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_spo(mem_spo), .mem_ready(mem_ready),
        .grant(grant), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit mdl_valid = 0;
    int mdl_owner = -1;   // -1: nobody owns the port
    bit mdl_rel   = 0;    // one idle cycle pending after an owner leaves
    int mdl_last  = 1;
    int mdl_wd    = 0;

    always @(negedge clk) begin : cmp
        logic [1:0]  req;
        logic        fire;
        logic        ob;
        logic [74:0] exp_mem, got_mem;
        logic [1:0]  exp_g, exp_rdy;
        logic [31:0] exp_spo0, exp_spo1;
        int          o, w;
        req  = m_rd | m_we;
        o    = mdl_owner;
        ob   = o[0];
        fire = (o >= 0) && (mdl_wd == TIMEOUT - 1) && !mem_ready;
        if (mdl_valid) begin
            exp_g    = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
            exp_mem  = (o >= 0) ? {m_be[ob], m_bl[ob], m_a[ob], m_d[ob], m_we[ob], m_rd[ob]} : '0;
            got_mem  = {mem_burst_en, mem_burst_length, mem_a, mem_d, mem_we, mem_rd};
            exp_rdy  = 2'b00;
            exp_spo0 = '0;
            exp_spo1 = '0;
            if (o == 0) begin
                exp_rdy[0] = mem_ready | fire;
                exp_spo0   = fire ? ERR_WORD : mem_spo;
            end else if (o == 1) begin
                exp_rdy[1] = mem_ready | fire;
                exp_spo1   = fire ? ERR_WORD : mem_spo;
            end
            check("mdl_grant", 128'(grant), 128'(exp_g));
            check("mdl_mem_bus", 128'(got_mem), 128'(exp_mem));
            check("mdl_ready", 128'({m1_ready, m0_ready}), 128'(exp_rdy));
            check("mdl_m0_spo", 128'(m0_spo), 128'(exp_spo0));
            check("mdl_m1_spo", 128'(m1_spo), 128'(exp_spo1));
            check("mdl_irq", 128'(timeout_irq), 128'(fire));
        end
        if (rst) begin
            mdl_valid <= 1;
            mdl_owner <= -1;
            mdl_rel   <= 0;
            mdl_last  <= 1;
            mdl_wd    <= 0;
        end else if (mdl_valid) begin
            if (o >= 0) begin
                mdl_wd <= (mem_ready || fire) ? 0 : mdl_wd + 1;
                if (!req[ob]) begin
                    mdl_owner <= -1;
                    mdl_rel   <= 1;
                end
            end else if (mdl_rel) begin
                mdl_rel <= 0;
            end else if (req != 2'b00) begin
                w = (req == 2'b11) ? 1 - mdl_last : (req[0] ? 0 : 1);
                mdl_owner <= w;
                mdl_last  <= w;
                mdl_wd    <= 0;
            end
        end
    end

    // ---------------- master and controller stimulus ----------------
    bit          ma_act[2], pend[2], rep[2], p_rd[2];
    int          left[2], gap[2], p_n[2];
    logic [31:0] p_a[2], p_d[2];
    bit          auto_en = 0, ctl_rand = 0;
    int          ctl_lat = 3, ctl_cnt = 0, cur_lat = 3;
    logic [31:0] ctl_data = '0;
    logic [1:0]  seen_ready = '0;
    bit          seen_active = 0, seen_mready = 0;

    task automatic pend_start(input int i, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input int n);
        p_rd[i] = rd; p_a[i] = a; p_d[i] = d; p_n[i] = n; pend[i] = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ma_act[i]) begin
                if (seen_ready[i]) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        ma_act[i] = 0;
                        m_rd[i] = 1'b0; m_we[i] = 1'b0;
                        m_a[i] = $urandom; m_d[i] = $urandom;
                        gap[i] = rep[i] ? 1 : int'($urandom_range(4, 1));
                    end
                end
            end else begin
                if (gap[i] > 0) gap[i]--;
                if (pend[i] || (gap[i] == 0 && (rep[i] || (auto_en && ($urandom % 3) == 0)))) begin
                    if (!pend[i] && !rep[i]) begin
                        p_rd[i] = 1'($urandom % 2);
                        p_a[i]  = $urandom;
                        p_d[i]  = $urandom;
                        p_n[i]  = (($urandom % 3) == 0) ? int'($urandom_range(8, 2)) : 1;
                    end
                    pend[i]   = 0;
                    ma_act[i] = 1;
                    left[i]   = p_n[i];
                    m_rd[i]   = p_rd[i];
                    m_we[i]   = !p_rd[i];
                    m_a[i]    = p_a[i];
                    m_d[i]    = p_d[i];
                    m_be[i]   = (p_n[i] > 1);
                    m_bl[i]   = (p_n[i] > 1) ? 8'(p_n[i]) : 8'h00;
                end
            end
        end
        if (!rst && seen_active && !seen_mready) ctl_cnt++;
        else ctl_cnt = 0;
        if (ctl_cnt == 0)
            cur_lat = ctl_rand ? ((($urandom % 10) == 0) ? 40 : int'($urandom_range(4, 1))) : ctl_lat;
        mem_ready = (ctl_cnt == cur_lat) || (ctl_rand && !seen_active && (($urandom % 8) == 0));
        mem_spo   = ctl_rand ? $urandom : ctl_data;
        #2;
        seen_ready  = {m1_ready, m0_ready};
        seen_active = mem_rd | mem_we;
        seen_mready = mem_ready;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ma_act[i] = 0; pend[i] = 0; rep[i] = 0; gap[i] = 0;
            m_rd[i] = 1'b0; m_we[i] = 1'b0;
        end
        seen_ready = '0; seen_active = 0; seen_mready = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_single();
        int  k;
        bit  m1_seen;
        ctl_lat = 3; ctl_data = 32'h1234_5678;
        pend_start(0, 1, 32'h8000_0010, 32'h0, 1);
        step();
        check("t1_rd_not_yet", 128'(mem_rd), 128'(0));
        check("t1_grant_idle", 128'(grant), 128'(0));
        step();
        check("t1_mem_rd", 128'(mem_rd), 128'(1));
        check("t1_mem_a", 128'(mem_a), 128'(32'h8000_0010));
        check("t1_grant01", 128'(grant), 128'(2'b01));
        m1_seen = 0;
        for (k = 0; k < 12; k++) begin
            if (m1_ready) m1_seen = 1;
            if (m0_ready) break;
            step();
        end
        check("t1_ready_latency", 128'(k), 128'(3));
        check("t1_m0_spo", 128'(m0_spo), 128'(32'h1234_5678));
        step();
        if (m1_ready) m1_seen = 1;
        check("t1_grant_held", 128'(grant), 128'(2'b01));
        step();
        if (m1_ready) m1_seen = 1;
        check("t1_grant_released", 128'(grant), 128'(2'b00));
        check("t1_release_rd", 128'(mem_rd), 128'(0));
        check("t1_m1_quiet", 128'(m1_seen), 128'(0));
    endtask

    task automatic test_alternate();
        logic [1:0] seq[$];
        logic [1:0] prev;
        int bad;
        do_reset();
        ctl_lat = 2; rep[0] = 1; rep[1] = 1;
        pend_start(0, 1, 32'h0000_1000, 32'h0, 1);
        pend_start(1, 1, 32'h0000_2000, 32'h0, 1);
        prev = 2'b00; bad = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (grant != 2'b00 && prev == 2'b00) seq.push_back(grant);
            if (grant != 2'b00 && prev != 2'b00 && grant != prev) bad++;
            if (grant == 2'b00 && prev != 2'b00)
                check("t2_release_idle", 128'({mem_rd, mem_we}), 128'(0));
            prev = grant;
        end
        check("t2_enough_grants", 128'(seq.size() >= 4), 128'(1));
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_grant_%0d", i), 128'((seq.size() > i) ? seq[i] : 2'b00),
                  128'((i % 2 == 0) ? 2'b01 : 2'b10));
        check("t2_no_direct_handover", 128'(bad), 128'(0));
        rep[0] = 0; rep[1] = 0;
    endtask

    task automatic test_burst();
        int n1, r8, g0, f10, bad;
        do_reset();
        ctl_lat = 1;
        pend_start(1, 1, 32'h4000_0000, 32'h0, 8);
        n1 = 0; r8 = -1; g0 = -1; f10 = -1; bad = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (grant == 2'b10 && f10 < 0) begin
                f10 = k;
                check("t3_burst_en", 128'(mem_burst_en), 128'(1));
                check("t3_burst_len", 128'(mem_burst_length), 128'(8));
            end
            if (f10 >= 0 && (r8 < 0 || k <= r8 + 1) && grant != 2'b10) bad++;
            if (grant == 2'b01 && g0 < 0) g0 = k;
            if (m1_ready) begin
                n1++;
                if (n1 == 3) pend_start(0, 0, 32'h0000_0100, 32'h5555_AAAA, 1);
                if (n1 == 8) r8 = k;
            end
        end
        check("t3_ready_pulses", 128'(n1), 128'(8));
        check("t3_grant_held", 128'(bad), 128'(0));
        check("t3_m0_after_release", 128'(g0), 128'(r8 + 4));
    endtask

    task automatic test_watchdog(input int lat, input bit expect_irq);
        int g, irqs, rdys;
        do_reset();
        ctl_lat = lat; ctl_data = 32'hCAFE_F00D;
        pend_start(0, 0, 32'h0000_0040, 32'h0BAD_F00D, 1);
        g = -1; irqs = 0; rdys = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (grant == 2'b01 && g < 0) g = k;
            if (g >= 0) begin
                if (timeout_irq) irqs++;
                if (m0_ready) rdys++;
                if (k - g == 14) check("t4_irq_early", 128'(timeout_irq), 128'(0));
                if (k - g == 15) begin
                    check("t4_ready16", 128'(m0_ready), 128'(1));
                    check("t4_spo16", 128'(m0_spo), 128'(expect_irq ? ERR_WORD : 32'hCAFE_F00D));
                    check("t4_irq16", 128'(timeout_irq), 128'(expect_irq));
                end
            end
        end
        check("t4_irq_count", 128'(irqs), 128'(expect_irq ? 1 : 0));
        check("t4_ready_count", 128'(rdys), 128'(1));
    endtask

    task automatic test_reset_mid();
        do_reset();
        ctl_lat = 1000;
        pend_start(1, 1, 32'h0000_0800, 32'h0, 1);
        for (int k = 0; k < 20; k++) begin
            step();
            if (grant == 2'b10) break;
        end
        check("t5_in_grant1", 128'(grant), 128'(2'b10));
        step();
        step();
        rst = 1'b1;
        ctl_lat = 2;
        pend_start(0, 1, 32'h0000_0900, 32'h0, 1);
        step();
        check("t5_reset_grant", 128'(grant), 128'(0));
        check("t5_reset_mem", 128'({mem_burst_en, mem_burst_length, mem_a, mem_d, mem_we, mem_rd}), 128'(0));
        check("t5_reset_m1_ready", 128'(m1_ready), 128'(0));
        rst = 1'b0;
        step();
        check("t5_tie_to_m0", 128'(grant), 128'(2'b01));
    endtask

    initial begin
        do_reset();
        check("t0_grant", 128'(grant), 128'(0));
        check("t0_irq", 128'(timeout_irq), 128'(0));
        check("t0_ready", 128'({m1_ready, m0_ready}), 128'(0));
        check("t0_spo", 128'({m1_spo, m0_spo}), 128'(0));
        check("t0_mem", 128'({mem_burst_en, mem_burst_length, mem_a, mem_d, mem_we, mem_rd}), 128'(0));
        test_single();
        test_alternate();
        test_burst();
        test_watchdog(1000, 1'b1);
        test_watchdog(15, 1'b0);
        test_reset_mid();

        do_reset();
        auto_en = 1; ctl_rand = 1;
        for (int k = 0; k < 4000; k++) begin
            step();
            rst = (($urandom % 800) == 0);
        end
        rst = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
